// File: rtl/stack_calc_p.sv
// rtl/stack_calc_p.sv - parametrised RPN stack calculator, top in a register, lower entries in RAM
// Optional macro STACK_CALC_P_STICKY_ERR_EN: err stays high from the first rejected operation until rst.
module stack_calc_p #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic                       step,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic [WIDTH-1:0]           d,
  input  logic [2:0]                 op,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_NEG  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_SUB  = 3'd4,
    OP_SWAP = 3'd5,
    OP_DUP  = 3'd6,
    OP_DROP = 3'd7
  } op_e;

  logic [WIDTH-1:0] ram [0:DEPTH-2];
  logic [WIDTH-1:0] top_q, top_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             err_q;

  logic [AW-1:0]    top_addr, sec_addr, wr_addr;
  logic [WIDTH-1:0] second, wr_data, prod;
  logic             we, rej;
  logic             has1, has2, not_full;

  // top_addr is where the current top spills to; sec_addr holds the entry just below it
  assign top_addr = AW'(cnt_q - CW'(1));
  assign sec_addr = AW'(cnt_q - CW'(2));
  assign second   = ram[sec_addr];
  assign prod     = second * top_q;

  assign has1     = (cnt_q != '0);
  assign has2     = (cnt_q >= CW'(2));
  assign not_full = (cnt_q < CNT_MAX);

  always_comb begin
    top_n   = top_q;
    cnt_n   = cnt_q;
    we      = 1'b0;
    wr_addr = top_addr;
    wr_data = top_q;
    rej     = 1'b0;
    if (en) begin
      if (push) begin
        if (not_full) begin
          we    = has1;
          top_n = d;
          cnt_n = cnt_q + CW'(1);
        end else begin
          rej = 1'b1;
        end
      end else begin
        case (op_e'(op))
          OP_NOP: ;
          OP_NEG: begin
            if (has1) top_n = -top_q;
            else      rej = 1'b1;
          end
          OP_ADD, OP_MUL, OP_SUB: begin
            if (has2) begin
              cnt_n = cnt_q - CW'(1);
              if (op_e'(op) == OP_ADD)      top_n = second + top_q;
              else if (op_e'(op) == OP_MUL) top_n = prod;
              else                          top_n = second - top_q;
            end else begin
              rej = 1'b1;
            end
          end
          OP_SWAP: begin
            if (has2) begin
              we      = 1'b1;
              wr_addr = sec_addr;
              top_n   = second;
            end else begin
              rej = 1'b1;
            end
          end
          OP_DUP: begin
            if (has1 && not_full) begin
              we    = 1'b1;
              cnt_n = cnt_q + CW'(1);
            end else begin
              rej = 1'b1;
            end
          end
          OP_DROP: begin
            if (has1) begin
              cnt_n = cnt_q - CW'(1);
              top_n = has2 ? second : '0;
            end else begin
              rej = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge step or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      top_q <= top_n;
      cnt_q <= cnt_n;
`ifdef STACK_CALC_P_STICKY_ERR_EN
      err_q <= err_q | rej;
`else
      err_q <= rej;
`endif
    end
  end

  // RAM contents survive reset; only writes are suppressed while rst is held
  always_ff @(posedge step) begin
    if (we && !rst) ram[wr_addr] <= wr_data;
  end

  assign out   = top_q;
  assign cnt   = cnt_q;
  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);
  assign err   = err_q;

endmodule

// File: tb/tb_stack_calc_p.sv
// tb/tb_stack_calc_p.sv - scoreboard bench for stack_calc_p against a queue-based stack model
module tb_stack_calc_p;

  localparam int W = 16;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          push = 1'b0;
  logic [W-1:0]  d = '0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  dout;
  logic [CW-1:0] cnt;
  logic          full, empty, err;

  stack_calc_p #(.WIDTH(W), .DEPTH(D)) dut (
    .step(clk), .rst(rst), .en(en), .push(push), .d(d), .op(op),
    .out(dout), .cnt(cnt), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    int           cnt;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] stk[$];
  logic         err_m = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model(input logic e, input logic p, input logic [2:0] o, input logic [W-1:0] v);
    logic rej;
    logic [W-1:0] a, b;
    rej = 1'b0;
    if (e) begin
      if (p) begin
        if (stk.size() < D) stk.push_back(v);
        else rej = 1'b1;
      end else begin
        case (o)
          3'd1: if (stk.size() >= 1) begin a = stk.pop_back(); stk.push_back(-a); end else rej = 1'b1;
          3'd2, 3'd3, 3'd4: begin
            if (stk.size() >= 2) begin
              a = stk.pop_back();
              b = stk.pop_back();
              if (o == 3'd2)      stk.push_back(b + a);
              else if (o == 3'd3) stk.push_back(b * a);
              else                stk.push_back(b - a);
            end else rej = 1'b1;
          end
          3'd5: if (stk.size() >= 2) begin
                  a = stk.pop_back(); b = stk.pop_back();
                  stk.push_back(a); stk.push_back(b);
                end else rej = 1'b1;
          3'd6: if (stk.size() >= 1 && stk.size() < D) stk.push_back(stk[$]); else rej = 1'b1;
          3'd7: if (stk.size() >= 1) void'(stk.pop_back()); else rej = 1'b1;
          default: ;
        endcase
      end
    end
`ifdef STACK_CALC_P_STICKY_ERR_EN
    err_m = err_m | rej;
`else
    err_m = rej;
`endif
  endtask

  task automatic do_step(input logic e, input logic p, input logic [2:0] o, input logic [W-1:0] v);
    exp_t x;
    @(negedge clk);
    en = e; push = p; op = o; d = v;
    model(e, p, o, v);
    x.out = (stk.size() > 0) ? stk[$] : '0;
    x.cnt = stk.size();
    x.err = err_m;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    stk.delete();
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("out", 32'(dout), 32'(x.out));
      chk("cnt", 32'(cnt), 32'(x.cnt));
      chk("err", 32'(err), 32'(x.err));
      chk("full", 32'(full), 32'(x.cnt == D));
      chk("empty", 32'(empty), 32'(x.cnt == 0));
    end
  end

  initial begin
    #1;
    chk("init_out", 32'(dout), 32'd0);
    chk("init_cnt", 32'(cnt), 32'd0);
    chk("init_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_step(1, 1, 0, 16'd5); do_step(1, 1, 0, 16'd7); do_step(1, 0, 2, 0);
    do_step(1, 1, 0, 16'd300); do_step(1, 0, 3, 0);
    do_reset();
    do_step(1, 1, 0, 16'd300); do_step(1, 1, 0, 16'd300); do_step(1, 0, 3, 0);
    do_step(1, 1, 0, 16'd10); do_step(1, 1, 0, 16'd3); do_step(1, 0, 4, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) do_step(1, 1, 0, 16'(i));
    do_step(1, 1, 0, 16'd9); do_step(1, 0, 0, 0); do_step(1, 0, 6, 0);
    do_step(1, 0, 2, 0); do_step(1, 0, 2, 0); do_step(1, 0, 2, 0);
    do_reset();
    do_step(1, 0, 2, 0); do_step(1, 1, 0, 16'd8); do_step(1, 0, 1, 0);
    do_step(1, 0, 7, 0); do_step(1, 0, 7, 0); do_step(0, 0, 0, 0);
    do_reset();
    do_step(1, 1, 0, 16'd1); do_step(1, 1, 0, 16'd2); do_step(1, 0, 5, 0);
    do_step(1, 0, 7, 0); do_step(1, 0, 6, 0); do_step(1, 0, 2, 0);
    do_step(1, 1, 2, 16'd6);
    do_step(1, 0, 2, 0); do_step(1, 0, 2, 0);
    for (int i = 0; i < 5; i++) do_step(1, 1, 0, 16'(i));
    do_reset();

    for (int i = 0; i < 600; i++) begin
      logic e, p;
      e = ($urandom_range(0, 9) != 0);
      p = ($urandom_range(0, 2) == 0);
      do_step(e, p, 3'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
